// File: rtl/ras_ctrl.sv
// Return-address-stack speculation controller: drives an external stack, logs each
// speculative push/pop with the value it destroyed, and unwinds the log on flush.
module ras_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEEP     = 8,
  parameter int LOG_DEEP = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_call,
  input  logic [WIDTH-1:0]           req_call_addr,
  input  logic                       req_ret,
  output logic                       req_ready,
  output logic                       pred_valid,
  output logic [WIDTH-1:0]           pred_addr,
  input  logic                       commit,
  input  logic                       flush,
  output logic                       busy,
  output logic [$clog2(DEEP+1)-1:0]  depth,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [WIDTH-1:0]           stk_data_in,
  input  logic [WIDTH-1:0]           stk_data_out,
  input  logic                       stk_empty
);

  localparam int DW = $clog2(DEEP + 1);
  localparam int LW = (LOG_DEEP > 1) ? $clog2(LOG_DEEP) : 1;
  localparam int CW = $clog2(LOG_DEEP + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEEP);
  localparam logic [CW-1:0] LOG_FULL  = CW'(LOG_DEEP);

  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_REPL} op_e;
  typedef enum logic {IDLE, UNWIND} state_e;

  state_e            state_q;
  logic [LW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic [DW-1:0]     depth_q, depth_d;

  op_e               log_op_q  [LOG_DEEP];
  logic [WIDTH-1:0]  log_top_q [LOG_DEEP];
  logic              log_vld_q [LOG_DEEP];

  logic              accept, commit_ok;
  op_e               new_op;
  logic [LW-1:0]     undo_idx;
  op_e               undo_op;
  logic [WIDTH-1:0]  undo_top;
  logic              undo_vld;

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] d);
    return (d == DEPTH_MAX) ? d : d + DW'(1);
  endfunction

  function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] d);
    return (d == '0) ? d : d - DW'(1);
  endfunction

  assign pred_valid = !stk_empty;
  assign pred_addr  = stk_data_out;
  assign busy       = (state_q == UNWIND);
  assign depth      = depth_q;

  always_comb begin
    req_ready   = (state_q == IDLE) && !flush && (count_q != LOG_FULL);
    accept      = req_ready && (req_call || req_ret);
    commit_ok   = (state_q == IDLE) && commit && (count_q != '0);
    new_op      = (req_call && req_ret) ? OP_REPL : (req_call ? OP_CALL : OP_RET);
    undo_idx    = tail_q - LW'(1);
    undo_op     = log_op_q[undo_idx];
    undo_top    = log_top_q[undo_idx];
    undo_vld    = log_vld_q[undo_idx];
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = req_call_addr;
    depth_d     = depth_q;
    if (state_q == IDLE) begin
      if (accept) begin
        case (new_op)
          OP_CALL: begin stk_push = 1'b1; depth_d = sat_inc(depth_q); end
          OP_RET:  begin stk_pop  = 1'b1; depth_d = sat_dec(depth_q); end
          default: begin
            stk_push = 1'b1;
            stk_pop  = 1'b1;
            depth_d  = (depth_q == '0) ? DW'(1) : depth_q;
          end
        endcase
      end
    end else begin
      // Undo the newest logged op; an empty-stack RET left nothing to restore.
      case (undo_op)
        OP_CALL: begin stk_pop = 1'b1; depth_d = sat_dec(depth_q); end
        OP_RET: begin
          if (undo_vld) begin
            stk_push    = 1'b1;
            stk_data_in = undo_top;
            depth_d     = sat_inc(depth_q);
          end
        end
        default: begin
          if (undo_vld) begin
            stk_push    = 1'b1;
            stk_pop     = 1'b1;
            stk_data_in = undo_top;
          end else begin
            stk_pop = 1'b1;
            depth_d = sat_dec(depth_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
      case (state_q)
        IDLE: begin
          if (accept)    tail_q <= tail_q + LW'(1);
          if (commit_ok) head_q <= head_q + LW'(1);
          count_q <= count_q + CW'(accept) - CW'(commit_ok);
          if (flush && ((count_q - CW'(commit_ok)) != '0)) state_q <= UNWIND;
        end
        default: begin
          tail_q  <= undo_idx;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) state_q <= IDLE;
        end
      endcase
    end
  end

  // Log payload carries no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      log_op_q[tail_q]  <= new_op;
      log_top_q[tail_q] <= stk_data_out;
      log_vld_q[tail_q] <= !stk_empty;
    end
  end

endmodule
